// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and index-width helpers for the mux_rr_sel selector.
package mux_pkg;

   localparam int unsigned MUX_N_DEFAULT  = 5;
   localparam int unsigned MUX_CH_DEFAULT = 4;
   localparam int unsigned MUX_CH_MAX     = 16;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

   // Channel index width, never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned ch);
      return (clog2(ch) < 1) ? 1 : clog2(ch);
   endfunction

endpackage

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: combinational rotating-priority arbiter. Grants the first
// requester at or above ptr, wrapping to the lowest requester below it.
module mux_rr_arb
   import mux_pkg::*;
#(
   parameter int unsigned CH    = MUX_CH_DEFAULT,
   parameter int unsigned SEL_W = sel_width(CH)
) (
   input  logic [CH-1:0]    req,
   input  logic [SEL_W-1:0] ptr,
   output logic [CH-1:0]    grant,
   output logic [SEL_W-1:0] idx
);

   logic found;

   // Pass one scans ptr..CH-1; pass two picks the lowest requester (the wrap).
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
         if (!found && req[i] && (32'(ptr) <= i)) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            idx      = SEL_W'(i);
         end
      end
      for (int unsigned i = 0; i < CH; i++) begin
         if (!found && req[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            idx      = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/mux_rr_sel.sv
// mux_rr_sel: CH-channel selector with valid/ready handshakes and a registered
// output stage. Define MUX_RR_SEL_ROUND_ROBIN_EN for round-robin arbitration;
// without it the lowest valid channel always wins and no ptr register exists.
module mux_rr_sel
   import mux_pkg::*;
#(
   parameter int unsigned N     = MUX_N_DEFAULT,
   parameter int unsigned CH    = MUX_CH_DEFAULT,
   parameter int unsigned SEL_W = sel_width(CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH*N-1:0]   in_data,
   input  logic [CH-1:0]     in_valid,
   output logic [CH-1:0]     in_ready,
   output logic [N-1:0]      out_data,
   output logic [SEL_W-1:0]  out_sel,
   output logic              out_valid,
   input  logic              out_ready
);

   logic             load_en;
   logic             any_grant;
   logic             take;
   logic [CH-1:0]    grant;
   logic [SEL_W-1:0] gnt_idx;
   logic [SEL_W-1:0] ptr;
   logic [N-1:0]     gnt_data;

   // Output register may be refilled when empty or being drained this cycle.
   assign load_en   = !out_valid | out_ready;
   assign any_grant = |grant;
   assign take      = load_en & any_grant;
   assign in_ready  = grant & {CH{load_en}};

   mux_rr_arb #(
      .CH    (CH),
      .SEL_W (SEL_W)
   ) u_arb (
      .req   (in_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gnt_idx)
   );

   // Select the granted channel's word (grant is one-hot or zero).
   always_comb begin
      gnt_data = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         if (grant[i]) gnt_data = in_data[i*N +: N];
      end
   end

`ifdef MUX_RR_SEL_ROUND_ROBIN_EN
   // Search start moves just past the accepted channel, with explicit wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (take) begin
         ptr <= (32'(gnt_idx) >= CH - 1) ? '0 : gnt_idx + SEL_W'(1);
      end
   end
`else
   assign ptr = '0;
`endif

   // Output stage: load on an accepted transfer, empty when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (load_en) begin
         out_valid <= any_grant;
         if (take) begin
            out_data <= gnt_data;
            out_sel  <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_sel.sv
// tb_mux_rr_sel: directed and randomized checks of mux_rr_sel (CH=4 and CH=3)
// against a queue-free behavioural model; follows MUX_RR_SEL_ROUND_ROBIN_EN.
module tb_mux_rr_sel;

`ifdef MUX_RR_SEL_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk;
   logic        rst_n;

   logic [19:0] in_data4;
   logic [3:0]  in_valid4;
   logic [3:0]  in_ready4;
   logic [4:0]  out_data4;
   logic [1:0]  out_sel4;
   logic        out_valid4;
   logic        out_ready4;

   logic [14:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [4:0]  out_data3;
   logic [1:0]  out_sel3;
   logic        out_valid3;
   logic        out_ready3;

   int checks   = 0;
   int failures = 0;

   // Model state, index 0 = CH4 instance, 1 = CH3 instance.
   logic       m_valid [2];
   logic [4:0] m_data  [2];
   int         m_sel   [2];
   int         m_ptr   [2];

   logic [3:0] last_rdy4;
   logic [2:0] last_rdy3;

   mux_rr_sel #(.N(5), .CH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
      .in_ready(in_ready4), .out_data(out_data4), .out_sel(out_sel4),
      .out_valid(out_valid4), .out_ready(out_ready4));

   mux_rr_sel #(.N(5), .CH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
      .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3),
      .out_valid(out_valid3), .out_ready(out_ready3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // First valid channel found by walking (p + k) mod ch.
   function automatic int pick(input logic [3:0] v, input int p, input int ch);
      for (int k = 0; k < ch; k++) begin
         int c;
         c = (p + k) % ch;
         if (((v >> c) & 4'd1) != 4'd0) return c;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_rdy(input int k, input logic [3:0] v, input logic ordy, input int ch);
      int g;
      if (m_valid[k] && !ordy) return 4'd0;
      g = pick(v, m_ptr[k], ch);
      if (g < 0) return 4'd0;
      return 4'(1 << g);
   endfunction

   task automatic step(input int k, input logic [3:0] v, input logic [19:0] d, input logic ordy, input int ch);
      int g;
      if (m_valid[k] && !ordy) return;
      g = pick(v, m_ptr[k], ch);
      if (g < 0) begin
         m_valid[k] = 1'b0;
      end else begin
         m_valid[k] = 1'b1;
         m_data[k]  = 5'(d >> (g * 5));
         m_sel[k]   = g;
         if (RR) m_ptr[k] = (g + 1) % ch;
      end
   endtask

   // Behavioural model advances on the same edges as the DUTs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = 5'd0;
            m_sel[k]   = 0;
            m_ptr[k]   = 0;
         end
      end else begin
         step(0, in_valid4, in_data4, out_ready4, 4);
         step(1, {1'b0, in_valid3}, {5'd0, in_data3}, out_ready3, 3);
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      logic [3:0] r4;
      logic [3:0] r3;
      r4 = exp_rdy(0, in_valid4, out_ready4, 4);
      r3 = exp_rdy(1, {1'b0, in_valid3}, out_ready3, 3);
      last_rdy4 = r4;
      last_rdy3 = r3[2:0];
      chk("out_valid4", 32'(out_valid4), 32'(m_valid[0]));
      chk("out_data4",  32'(out_data4),  32'(m_data[0]));
      chk("out_sel4",   32'(out_sel4),   32'(m_sel[0]));
      chk("in_ready4",  32'(in_ready4),  32'(r4));
      chk("out_valid3", 32'(out_valid3), 32'(m_valid[1]));
      chk("out_data3",  32'(out_data3),  32'(m_data[1]));
      chk("out_sel3",   32'(out_sel3),   32'(m_sel[1]));
      chk("in_ready3",  32'(in_ready3),  32'(r3[2:0]));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int fair_rr [8];
      int thr;
      logic [4:0] bp_exp;
      fair_rr = '{0, 1, 2, 3, 0, 1, 2, 3};

      rst_n = 1'b0;
      in_data4 = '0; in_valid4 = '0; out_ready4 = 1'b0;
      in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid4), 32'd0);
      chk("rst_out_data",  32'(out_data4),  32'd0);
      chk("rst_out_sel",   32'(out_sel4),   32'd0);
      chk("rst_in_ready",  32'(in_ready4),  32'd0);
      rst_n = 1'b1;

      // Single source on channel 2.
      in_valid4 = 4'b0100;
      in_data4  = {5'h00, 5'h15, 5'h00, 5'h00};
      out_ready4 = 1'b1;
      #1;
      chk("single_in_ready", 32'(in_ready4), 32'h4);
      tick();
      chk("single_data",  32'(out_data4),  32'h15);
      chk("single_sel",   32'(out_sel4),   32'd2);
      chk("single_valid", 32'(out_valid4), 32'd1);
      in_valid4 = 4'b0000;
      tick();
      chk("single_drain", 32'(out_valid4), 32'd0);

      // Fairness with every channel valid.
      pulse_reset();
      in_valid4 = 4'hF;
      in_data4  = {5'd13, 5'd12, 5'd11, 5'd10};
      for (int e = 0; e < 8; e++) begin
         tick();
         chk("fair_sel",  32'(out_sel4),  32'(RR ? fair_rr[e] : 0));
         chk("fair_data", 32'(out_data4), 32'(RR ? 10 + fair_rr[e] : 10));
      end

      // Wrap and skip: last grant was ch3, now only ch1 and ch3 request.
      in_valid4 = 4'b1010;
      tick();
      chk("skip_sel_a", 32'(out_sel4), 32'd1);
      tick();
      chk("skip_sel_b", 32'(out_sel4), 32'(RR ? 3 : 1));
      bp_exp = RR ? 5'd13 : 5'd11;

      // Backpressure, then drain and load on the same edge.
      out_ready4 = 1'b0;
      in_valid4  = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready4), 32'd0);
         tick();
         chk("bp_data",  32'(out_data4),  32'(bp_exp));
         chk("bp_valid", 32'(out_valid4), 32'd1);
      end
      out_ready4 = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(in_ready4), 32'h2);
      tick();
      chk("bp_load_sel",   32'(out_sel4),   32'd1);
      chk("bp_load_data",  32'(out_data4),  32'd11);
      chk("bp_load_valid", 32'(out_valid4), 32'd1);
      in_valid4 = 4'b0000;
      tick();
      chk("bp_empty", 32'(out_valid4), 32'd0);

      // Asynchronous reset while the output register holds a word.
      in_valid4 = 4'hF;
      tick();
      chk("mid_pre_valid", 32'(out_valid4), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_valid",    32'(out_valid4), 32'd0);
      chk("mid_data",     32'(out_data4),  32'd0);
      chk("mid_sel",      32'(out_sel4),   32'd0);
      chk("mid_in_ready", 32'(in_ready4),  32'h1);
      rst_n = 1'b1;
      tick();
      chk("post_rst_sel",  32'(out_sel4),  32'd0);
      chk("post_rst_data", 32'(out_data4), 32'd10);
      in_valid4 = 4'b0000;

      // Three-channel instance wrap.
      in_valid3  = 3'b111;
      in_data3   = {5'd22, 5'd21, 5'd20};
      out_ready3 = 1'b1;
      for (int e = 0; e < 4; e++) begin
         tick();
         chk("ch3_sel", 32'(out_sel3), 32'(RR ? e % 3 : 0));
      end
      in_valid3 = 3'b000;
      tick();

      // Randomized traffic obeying the producer hold rule.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (cyc == 1500) pulse_reset();
         thr = ((cyc / 250) % 3 == 0) ? 2 : (((cyc / 250) % 3 == 1) ? 6 : 10);
         for (int i = 0; i < 4; i++) begin
            if (!in_valid4[i] || last_rdy4[i]) begin
               in_valid4[i] = ($urandom_range(0, 9) < thr);
               in_data4[i*5 +: 5] = 5'($urandom);
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (!in_valid3[i] || last_rdy3[i]) begin
               in_valid3[i] = ($urandom_range(0, 9) < thr);
               in_data3[i*5 +: 5] = 5'($urandom);
            end
         end
         out_ready4 = ($urandom_range(0, 3) != 0);
         out_ready3 = ($urandom_range(0, 3) != 0);
      end
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_rr_sel.md
# mux_rr_sel

Parametrised N-bit, CH-channel selector with round-robin arbitration, valid/ready handshakes and a registered output. It is the sequential successor to the plain 2-way select used in the ALU datapath. It merges up to CH producers, such as ALU result sources or operand fetch paths, into one registered stream. Throughput is one word per cycle.

## Interface
Parameters:
- N, default 5: data width per channel.
- CH, default 4: channel count, 1..16, power of two not required.
- SEL_W, default clog2(CH), minimum 1: width of the `out_sel` index.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  CH*N  packed channel data; channel i occupies [i*N +: N].
- in_valid  input  CH  per-channel valid.
- in_ready  output  CH  per-channel ready; one-hot or zero.
- out_data  output  N  registered selected data.
- out_sel  output  SEL_W  registered index of the channel that supplied `out_data`.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

## Operation
Handshake rules:
- A transfer occurs when valid and ready are both high on an edge.
- A producer holds `in_data` stable and keeps `in_valid` asserted until it is accepted.
- `in_valid` never depends on `in_ready`.

Arbitration and load:
- load_en = !out_valid | out_ready.
- Grant goes to the first channel with `in_valid` high, searching from `ptr` upward and wrapping from CH-1 to 0. Grant is combinational.
- in_ready[i] = grant[i] & load_en. At most one bit is high. All bits are 0 when no channel is valid.

On an edge with load_en high and some grant g:
- `out_data` <= channel g data.
- `out_sel` <= g.
- `out_valid` <= 1.
- `ptr` <= g+1, wrapping to 0 after CH-1. For non-power-of-two CH the wrap is explicit, not modulo 2^SEL_W.

On an edge with load_en high and no grant:
- `out_valid` <= 0.
- `out_data`, `out_sel` and `ptr` are held.

With `out_valid` high and `out_ready` low:
- All registers hold.
- All `in_ready` bits are 0.

Simultaneous drain and load in the same cycle is allowed. The output register is replaced with no bubble.

`ptr` advances only on an accepted input transfer. It never advances while idle or stalled.

With CH=1 the arbiter degenerates to pass-through: `out_sel` is always 0 and `ptr` stays 0.

## Timing
- Latency is 1 cycle from input acceptance to `out_valid`/`out_data`.
- Sustained throughput is 1 word per cycle while `out_ready` is high and any channel is valid.
- Combinational paths: `in_valid` and `out_ready` to `in_ready`. There is no combinational path from input to `out_*`.

Reset:
- Asynchronous assertion: `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0 immediately, including mid-transfer.
- `in_ready` then follows load_en=1.
- Deassertion is synchronous to `clk` via an external synchronizer.
- A word held in the output register at reset is discarded.

## Configuration
- MUX_RR_SEL_ROUND_ROBIN_EN defined: round-robin arbitration as described, with the `ptr` register present.
- Not defined: fixed priority, lowest index wins. `ptr` is not implemented and the search always starts at 0. All other behaviour is identical.

## Structure
- Shared package `mux_pkg` holds:
  - the clog2 function;
  - the default N (5) and CH (4);
  - a localparam for the maximum CH (16).
- Sub-module `mux_rr_arb`:
  - inputs: req[CH], ptr[SEL_W];
  - outputs: one-hot grant[CH] and the encoded index;
  - purely combinational.
- The top level holds `ptr`, the output register and the handshake logic.

## Test plan
All scenarios use N=5, CH=4 unless stated.
- Reset: assert rst_n=0 mid-transfer while out_valid=1 → out_valid, out_data and out_sel go to 0 without waiting for a clock edge. After release, first grant is channel 0 when all channels are valid.
- Single source: ch2 valid with data 5'h15, out_ready=1 → in_ready=4'b0100. Next cycle out_data=5'h15, out_sel=2, out_valid=1.
- Fairness: all channels valid with distinct data, out_ready held 1 → out_sel sequence 0,1,2,3,0 on consecutive cycles. With MUX_RR_SEL_ROUND_ROBIN_EN undefined, the sequence is 0,0,0,0,0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles → out_data stable, in_ready=0. Raise out_ready with ch1 valid → same edge drains and loads ch1, no idle cycle.
- Wrap and skip: last grant ch3 (ptr=0), then only ch1 and ch3 valid → grants ch1 then ch3.
- CH=3: all channels valid → out_sel sequence 0,1,2,0. `ptr` never reaches 3.
